// File: rtl/matmul_sched_pkg.sv
// Shared types and constants for the matrix-multiplier job scheduler.
//   state_t      : scheduler FSM states
//   addr_t       : RAM address at the default 32-bit width
//   MAX_NUM_REQ  : largest supported requester count
package matmul_sched_pkg;

  localparam int MAX_NUM_REQ        = 8;
  localparam int DEFAULT_ADDR_WIDTH = 32;

  typedef logic [DEFAULT_ADDR_WIDTH-1:0] addr_t;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    RUN,
    RETIRE,
    ABORT
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Scans the request vector starting one position after ptr, wrapping modulo N,
// and grants the first set bit.
//   req : request vector, one bit per requester
//   ptr : index of the previous winner; it gets lowest priority this round
//   gnt : one-hot grant, all zero when nothing is requested
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    // k = 1..N visits ptr+1 first and ptr itself last.
    for (int k = 1; k <= N; k++) begin
      idx = PTR_W'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/matmul_job_scheduler.sv
// Shares one matrix_multiplier engine among NUM_REQ requesters.
// A round-robin winner has its X/Y/Z base addresses latched. The engine is
// started and watched until busy falls or the watchdog expires. Then done (and
// err on abort) is pulsed to the owner. Engine local addresses are offset by the
// latched bases on the way to the shared RAM ports.
// Ports:
//   clk, rst                       clock; asynchronous active-high reset
//   req[NUM_REQ]                   level job requests, held until done
//   x_base/y_base/z_base           packed per-requester base addresses
//   grant[NUM_REQ]                 one-hot engine owner for the whole job
//   done[NUM_REQ], err             completion pulse to the owner; err marks abort
//   mm_start, mm_rst               engine start / abort-reset pulses
//   mm_busy, mm_*_addr, mm_z_wen   engine status and local addresses
//   ram_*_addr, ram_z_wen          offset addresses and gated Z write enable
module matmul_job_scheduler
  import matmul_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_CYCLES = 65535
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] x_base,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] y_base,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] z_base,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            done,
  output logic                          err,
  output logic                          mm_start,
  output logic                          mm_rst,
  input  logic                          mm_busy,
  input  logic [ADDR_WIDTH-1:0]         mm_x_addr,
  input  logic [ADDR_WIDTH-1:0]         mm_y_addr,
  input  logic [ADDR_WIDTH-1:0]         mm_z_addr,
  input  logic                          mm_z_wen,
  output logic [ADDR_WIDTH-1:0]         ram_x_addr,
  output logic [ADDR_WIDTH-1:0]         ram_y_addr,
  output logic [ADDR_WIDTH-1:0]         ram_z_addr,
  output logic                          ram_z_wen
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = $clog2(MAX_CYCLES + 1);

  if (NUM_REQ < 2 || NUM_REQ > MAX_NUM_REQ) begin : g_num_req_check
    $error("matmul_job_scheduler: NUM_REQ out of supported range");
  end

  // Per-requester views of the packed base buses
  logic [ADDR_WIDTH-1:0] x_base_arr [NUM_REQ];
  logic [ADDR_WIDTH-1:0] y_base_arr [NUM_REQ];
  logic [ADDR_WIDTH-1:0] z_base_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign x_base_arr[gi] = x_base[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign y_base_arr[gi] = y_base[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign z_base_arr[gi] = z_base[gi*ADDR_WIDTH +: ADDR_WIDTH];
  end

  state_t                state_reg,  state_next;
  logic [PTR_W-1:0]      ptr_reg,    ptr_next;
  logic [NUM_REQ-1:0]    grant_reg,  grant_next;
  logic [ADDR_WIDTH-1:0] x_base_reg, x_base_next;
  logic [ADDR_WIDTH-1:0] y_base_reg, y_base_next;
  logic [ADDR_WIDTH-1:0] z_base_reg, z_base_next;
  logic [WD_W-1:0]       wd_reg,     wd_next;

  logic [NUM_REQ-1:0]    arb_gnt;
  logic [PTR_W-1:0]      win_idx;
  logic                  z_wen_en;

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req (req),
    .ptr (ptr_reg),
    .gnt (arb_gnt)
  );

  // One-hot to index; the winner becomes the next lowest-priority slot.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) win_idx = PTR_W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      ptr_reg    <= PTR_W'(NUM_REQ - 1);
      grant_reg  <= '0;
      x_base_reg <= '0;
      y_base_reg <= '0;
      z_base_reg <= '0;
      wd_reg     <= '0;
    end else begin
      state_reg  <= state_next;
      ptr_reg    <= ptr_next;
      grant_reg  <= grant_next;
      x_base_reg <= x_base_next;
      y_base_reg <= y_base_next;
      z_base_reg <= z_base_next;
      wd_reg     <= wd_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    ptr_next    = ptr_reg;
    grant_next  = grant_reg;
    x_base_next = x_base_reg;
    y_base_next = y_base_reg;
    z_base_next = z_base_reg;
    wd_next     = wd_reg;
    done        = '0;
    err         = 1'b0;
    mm_start    = 1'b0;
    mm_rst      = 1'b0;
    z_wen_en    = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (|req) begin
          grant_next  = arb_gnt;
          ptr_next    = win_idx;
          x_base_next = x_base_arr[win_idx];
          y_base_next = y_base_arr[win_idx];
          z_base_next = z_base_arr[win_idx];
          state_next  = LAUNCH;
        end
      end
      LAUNCH: begin
        // Engine busy only rises after this pulse, so it is not looked at here.
        mm_start   = 1'b1;
        wd_next    = '0;
        state_next = RUN;
      end
      RUN: begin
        z_wen_en = 1'b1;
        wd_next  = wd_reg + WD_W'(1);
        if (!mm_busy) begin
          state_next = RETIRE;
        end else if (wd_reg == WD_W'(MAX_CYCLES)) begin
          state_next = ABORT;
        end
      end
      RETIRE: begin
        done        = grant_reg;
        grant_next  = '0;
        x_base_next = '0;
        y_base_next = '0;
        z_base_next = '0;
        state_next  = IDLE;
      end
      ABORT: begin
        mm_rst      = 1'b1;
        done        = grant_reg;
        err         = 1'b1;
        grant_next  = '0;
        x_base_next = '0;
        y_base_next = '0;
        z_base_next = '0;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign grant      = grant_reg;
  // Bases are zero outside a job, so these pass the engine address straight through then.
  assign ram_x_addr = x_base_reg + mm_x_addr;
  assign ram_y_addr = y_base_reg + mm_y_addr;
  assign ram_z_addr = z_base_reg + mm_z_addr;
  assign ram_z_wen  = mm_z_wen & z_wen_en;

endmodule

// File: tb/tb_matmul_job_scheduler.sv
// Directed testbench for matmul_job_scheduler (4 requesters, watchdog of 20).
module tb_matmul_job_scheduler;
  import matmul_sched_pkg::*;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int MC = 20;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [NR-1:0]  req = '0;
  logic [NR*AW-1:0] x_base = '0, y_base = '0, z_base = '0;
  logic [NR-1:0]  grant, done;
  logic           err, mm_start, mm_rst;
  logic           mm_busy = 1'b0;
  addr_t          mm_x_addr = '0, mm_y_addr = '0, mm_z_addr = '0;
  logic           mm_z_wen = 1'b0;
  addr_t          ram_x_addr, ram_y_addr, ram_z_addr;
  logic           ram_z_wen;

  int checks   = 0;
  int failures = 0;

  matmul_job_scheduler #(
    .NUM_REQ    (NR),
    .ADDR_WIDTH (AW),
    .MAX_CYCLES (MC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .x_base     (x_base),
    .y_base     (y_base),
    .z_base     (z_base),
    .grant      (grant),
    .done       (done),
    .err        (err),
    .mm_start   (mm_start),
    .mm_rst     (mm_rst),
    .mm_busy    (mm_busy),
    .mm_x_addr  (mm_x_addr),
    .mm_y_addr  (mm_y_addr),
    .mm_z_addr  (mm_z_addr),
    .mm_z_wen   (mm_z_wen),
    .ram_x_addr (ram_x_addr),
    .ram_y_addr (ram_y_addr),
    .ram_z_addr (ram_z_addr),
    .ram_z_wen  (ram_z_wen)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Tick until mm_start is seen, bounded.
  task automatic wait_start(output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (cyc < 8 && !ok) begin
      tick();
      cyc++;
      if (mm_start === 1'b1) ok = 1'b1;
    end
  endtask

  // Called while LAUNCH is visible: busy for n cycles, then falls; returns the
  // done value seen in the cycle busy fell and leaves RETIRE visible.
  task automatic engine_job(input int n, output logic [NR-1:0] done_at_fall);
    mm_busy = 1'b1;
    repeat (n) tick();
    mm_busy = 1'b0;
    done_at_fall = done;
    tick();
  endtask

  task automatic test_reset();
    mm_x_addr = 32'd5;
    #($urandom_range(3, 17));
    rst = 1'b1;
    #1;
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant: got=%b want=0000", grant); end
    checks++; if (done !== 4'b0000) begin failures++; $display("FAIL reset_done: got=%b want=0000", done); end
    checks++; if ({err, mm_start, mm_rst, ram_z_wen} !== 4'b0000) begin failures++; $display("FAIL reset_pulses: got=%b want=0000", {err, mm_start, mm_rst, ram_z_wen}); end
    checks++; if (ram_x_addr !== 32'd5) begin failures++; $display("FAIL reset_ram_x: got=%h want=00000005", ram_x_addr); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mm_x_addr = '0;
    $display("reset: grant=%b done=%b err=%b", grant, done, err);
  endtask

  task automatic test_first_grant();
    req = 4'b0001;
    tick();
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL first_grant: got=%b want=0001", grant); end
    checks++; if (mm_start !== 1'b1) begin failures++; $display("FAIL first_start: got=%b want=1", mm_start); end
    mm_busy = 1'b1;
    tick();
    checks++; if ({mm_start, grant} !== 5'b0_0001) begin failures++; $display("FAIL first_start_pulse: start,grant got=%b want=00001", {mm_start, grant}); end
    tick();
    tick();
    mm_busy = 1'b0;
    checks++; if (done !== 4'b0000) begin failures++; $display("FAIL first_done_early: got=%b want=0000", done); end
    tick();
    checks++; if ({done, err} !== 5'b0001_0) begin failures++; $display("FAIL first_done: done,err got=%b want=00010", {done, err}); end
    req = 4'b0000;
    tick();
    checks++; if ({done, grant} !== 8'h00) begin failures++; $display("FAIL first_retire: done,grant got=%b want=00000000", {done, grant}); end
    $display("first job: requester 0 done");
  endtask

  task automatic test_offset();
    int cyc;
    bit ok;
    for (int i = 0; i < NR; i++) begin
      x_base[i*AW +: AW] = 32'hA000_0000 + i;
      y_base[i*AW +: AW] = 32'hB000_0000 + i;
      z_base[i*AW +: AW] = 32'hC000_0000 + i;
    end
    x_base[1*AW +: AW] = 32'h100;
    y_base[1*AW +: AW] = 32'h200;
    z_base[1*AW +: AW] = 32'h300;
    req = 4'b0010;
    wait_start(cyc, ok);
    checks++; if (!ok || cyc != 1) begin failures++; $display("FAIL offset_latency: cycles=%0d seen=%0d want=1", cyc, ok); end
    checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL offset_grant: got=%b want=0010", grant); end
    mm_x_addr = 32'd3;
    mm_y_addr = 32'd7;
    mm_z_addr = 32'h10;
    mm_z_wen  = 1'b1;
    #1;
    checks++; if (ram_x_addr !== 32'h103) begin failures++; $display("FAIL offset_x: got=%h want=00000103", ram_x_addr); end
    checks++; if (ram_y_addr !== 32'h207) begin failures++; $display("FAIL offset_y: got=%h want=00000207", ram_y_addr); end
    checks++; if (ram_z_addr !== 32'h310) begin failures++; $display("FAIL offset_z: got=%h want=00000310", ram_z_addr); end
    checks++; if (ram_z_wen !== 1'b0) begin failures++; $display("FAIL offset_wen_launch: got=%b want=0", ram_z_wen); end
    mm_busy = 1'b1;
    tick();
    checks++; if (ram_z_wen !== 1'b1) begin failures++; $display("FAIL offset_wen_run: got=%b want=1", ram_z_wen); end
    tick();
    tick();
    mm_busy = 1'b0;
    tick();
    checks++; if (done !== 4'b0010) begin failures++; $display("FAIL offset_done: got=%b want=0010", done); end
    req = 4'b0000;
    tick();
    checks++; if ({ram_x_addr, ram_z_wen} !== {32'd3, 1'b0}) begin failures++; $display("FAIL offset_idle: ram_x=%h wen=%b want=00000003 0", ram_x_addr, ram_z_wen); end
    mm_z_wen = 1'b0;
    $display("offset job: requester 1 ram_x=0x103 ram_y=0x207 ram_z=0x310");
  endtask

  task automatic test_wrap();
    int cyc;
    bit ok;
    logic [NR-1:0] d;
    x_base[3*AW +: AW] = 32'hFFFF_FFFF;
    y_base[3*AW +: AW] = 32'h8000_0000;
    z_base[3*AW +: AW] = 32'hFFFF_FFFE;
    req = 4'b1000;
    wait_start(cyc, ok);
    checks++; if (!ok || grant !== 4'b1000) begin failures++; $display("FAIL wrap_grant: got=%b seen=%0d want=1000", grant, ok); end
    mm_x_addr = 32'd1;
    mm_y_addr = 32'h8000_0001;
    mm_z_addr = 32'd3;
    #1;
    checks++; if (ram_x_addr !== 32'h0) begin failures++; $display("FAIL wrap_x: got=%h want=00000000", ram_x_addr); end
    checks++; if (ram_y_addr !== 32'h1) begin failures++; $display("FAIL wrap_y: got=%h want=00000001", ram_y_addr); end
    checks++; if (ram_z_addr !== 32'h1) begin failures++; $display("FAIL wrap_z: got=%h want=00000001", ram_z_addr); end
    engine_job(2, d);
    checks++; if (done !== 4'b1000) begin failures++; $display("FAIL wrap_done: got=%b want=1000", done); end
    req = 4'b0000;
    tick();
    mm_x_addr = '0;
    mm_y_addr = '0;
    mm_z_addr = '0;
    $display("wrap job: requester 3 ram_z=0x00000001");
  endtask

  task automatic test_fairness();
    int order [5];
    int cyc;
    bit ok;
    logic [NR-1:0] d;
    logic [NR-1:0] exp_g;
    order = '{0, 1, 2, 3, 0};
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      exp_g = 4'b0001 << order[j];
      wait_start(cyc, ok);
      checks++; if (!ok || cyc != 1) begin failures++; $display("FAIL fair_gap%0d: cycles=%0d seen=%0d want=1", j, cyc, ok); end
      checks++; if (grant !== exp_g) begin failures++; $display("FAIL fair_grant%0d: got=%b want=%b", j, grant, exp_g); end
      checks++; if ($countones(grant) != 1) begin failures++; $display("FAIL fair_onehot%0d: got=%b want one bit", j, grant); end
      engine_job(1 + j, d);
      checks++; if (d !== 4'b0000) begin failures++; $display("FAIL fair_early%0d: got=%b want=0000", j, d); end
      checks++; if (done !== exp_g) begin failures++; $display("FAIL fair_done%0d: got=%b want=%b", j, done, exp_g); end
      if (j == 4) req = 4'b0000;
      tick();
      checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL fair_idle%0d: got=%b want=0000", j, grant); end
      $display("fairness job %0d: grant=%b", j, exp_g);
    end
  endtask

  task automatic test_watchdog();
    int cyc;
    bit ok;
    bit wen_ok;
    req = 4'b0010;
    wait_start(cyc, ok);
    checks++; if (!ok || grant !== 4'b0010) begin failures++; $display("FAIL wd_grant: got=%b seen=%0d want=0010", grant, ok); end
    mm_busy  = 1'b1;
    mm_z_wen = 1'b1;
    cyc    = 0;
    wen_ok = 1'b1;
    while (cyc < 40 && mm_rst !== 1'b1) begin
      tick();
      cyc++;
      if (mm_rst !== 1'b1 && ram_z_wen !== 1'b1) wen_ok = 1'b0;
    end
    checks++; if (cyc != MC + 2) begin failures++; $display("FAIL wd_cycles: start-to-mm_rst=%0d want=%0d", cyc, MC + 2); end
    checks++; if (wen_ok !== 1'b1) begin failures++; $display("FAIL wd_run_wen: got=%b want=1", wen_ok); end
    checks++; if ({done, err} !== 5'b0010_1) begin failures++; $display("FAIL wd_abort: done,err got=%b want=00101", {done, err}); end
    checks++; if (ram_z_wen !== 1'b0) begin failures++; $display("FAIL wd_abort_wen: got=%b want=0", ram_z_wen); end
    req = 4'b0000;
    tick();
    checks++; if ({mm_rst, err, done, grant, ram_z_wen} !== 11'b0) begin failures++; $display("FAIL wd_after: rst,err,done,grant,wen got=%b want=0", {mm_rst, err, done, grant, ram_z_wen}); end
    mm_busy  = 1'b0;
    mm_z_wen = 1'b0;
    $display("watchdog job: requester 1 aborted after %0d cycles", cyc);
  endtask

  task automatic test_req_drop();
    int cyc;
    bit ok;
    req = 4'b0100;
    wait_start(cyc, ok);
    checks++; if (!ok || grant !== 4'b0100) begin failures++; $display("FAIL drop_grant: got=%b seen=%0d want=0100", grant, ok); end
    mm_busy = 1'b1;
    tick();
    req = 4'b0000;
    tick();
    tick();
    mm_busy = 1'b0;
    tick();
    checks++; if (done !== 4'b0100) begin failures++; $display("FAIL drop_done: got=%b want=0100", done); end
    tick();
    tick();
    checks++; if ({grant, mm_start} !== 5'b0) begin failures++; $display("FAIL drop_idle: grant,start got=%b want=00000", {grant, mm_start}); end
    $display("req drop job: requester 2 still done");
  endtask

  task automatic test_rst_midjob();
    int cyc;
    bit ok;
    logic [NR-1:0] d;
    req = 4'b0001;
    wait_start(cyc, ok);
    checks++; if (!ok || grant !== 4'b0001) begin failures++; $display("FAIL rstmid_grant: got=%b seen=%0d want=0001", grant, ok); end
    mm_busy = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL rstmid_async: got=%b want=0000", grant); end
    mm_busy = 1'b0;
    req = 4'b0000;
    tick();
    checks++; if ({done, err, mm_start} !== 6'b0) begin failures++; $display("FAIL rstmid_pulses: done,err,start got=%b want=000000", {done, err, mm_start}); end
    rst = 1'b0;
    tick();
    checks++; if ({done, grant} !== 8'h00) begin failures++; $display("FAIL rstmid_after: done,grant got=%b want=00000000", {done, grant}); end
    // Pointer must be back at NUM_REQ-1, so requester 0 beats requester 1.
    req = 4'b0011;
    wait_start(cyc, ok);
    checks++; if (!ok || grant !== 4'b0001) begin failures++; $display("FAIL rstmid_ptr: got=%b seen=%0d want=0001", grant, ok); end
    engine_job(1, d);
    checks++; if (done !== 4'b0001) begin failures++; $display("FAIL rstmid_done: got=%b want=0001", done); end
    req = 4'b0000;
    tick();
    $display("reset mid-job: no done, pointer restored");
  endtask

  initial begin
    test_reset();
    test_first_grant();
    test_offset();
    test_wrap();
    test_fairness();
    test_watchdog();
    test_req_drop();
    test_rst_midjob();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
